// File: rtl/alarm_ctrl.sv
// Alarm sequencer: compares the running time word with the stored alarm time and
// drives the ring / snooze / stop behaviour, the alarm LEDs and the buzzer.
module alarm_ctrl #(
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned SNOOZE_S       = 300,
  parameter int unsigned MAX_SNOOZE     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic [13:0] cur_time,
  input  logic [13:0] alarm_time,
  input  logic        alarm_en,
  input  logic        btn_stop,
  input  logic        btn_snooze,
  output logic        armed,
  output logic        ringing,
  output logic        snoozing,
  output logic        buzzer,
  output logic [1:0]  snooze_left
);

  localparam int unsigned RW = (RING_TIMEOUT_S > 1) ? $clog2(RING_TIMEOUT_S) : 1;
  localparam int unsigned SW = (SNOOZE_S > 1) ? $clog2(SNOOZE_S) : 1;

  localparam logic [RW-1:0] RING_LAST   = RW'(RING_TIMEOUT_S - 1);
  localparam logic [SW-1:0] SNOOZE_LAST = SW'(SNOOZE_S - 1);
  localparam logic [1:0]    SNOOZE_MAX  = 2'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_RINGING = 2'd2,
    S_SNOOZE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic [SW-1:0] snooze_cnt_q, snooze_cnt_d;
  logic          blink_q, blink_d;
  logic [1:0]    snooze_left_q, snooze_left_d;
  logic          match_q;

  logic match;
  logic trigger;

  assign match   = (cur_time == alarm_time);
  // Rising edge of equality: fires once per entry into the matching minute.
  assign trigger = match & ~match_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ring_cnt_q    <= '0;
      snooze_cnt_q  <= '0;
      blink_q       <= 1'b0;
      snooze_left_q <= SNOOZE_MAX;
      match_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      ring_cnt_q    <= ring_cnt_d;
      snooze_cnt_q  <= snooze_cnt_d;
      blink_q       <= blink_d;
      snooze_left_q <= snooze_left_d;
      match_q       <= match;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path can leave
  // a value unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    ring_cnt_d    = ring_cnt_q;
    snooze_cnt_d  = snooze_cnt_q;
    blink_d       = blink_q;
    snooze_left_d = snooze_left_q;

    if (!alarm_en) begin
      state_d = S_IDLE;
      blink_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_ARMED;
        end

        S_ARMED: begin
          if (trigger) begin
            state_d       = S_RINGING;
            ring_cnt_d    = '0;
            blink_d       = 1'b1;
            snooze_left_d = SNOOZE_MAX;
          end
        end

        S_RINGING: begin
          // Button transitions win over a coincident tick; an ignored snooze
          // press is no transition, so the tick still counts.
          if (btn_stop) begin
            state_d = S_ARMED;
            blink_d = 1'b0;
          end else if (btn_snooze && (snooze_left_q != 2'd0)) begin
            state_d       = S_SNOOZE;
            snooze_cnt_d  = '0;
            snooze_left_d = snooze_left_q - 2'd1;
            blink_d       = 1'b0;
          end else if (tick_1hz) begin
            if (ring_cnt_q == RING_LAST) begin
              state_d = S_ARMED;
              blink_d = 1'b0;
            end else begin
              ring_cnt_d = ring_cnt_q + RW'(1);
              blink_d    = ~blink_q;
            end
          end
        end

        S_SNOOZE: begin
          if (btn_stop) begin
            state_d = S_ARMED;
          end else if (tick_1hz) begin
            if (snooze_cnt_q == SNOOZE_LAST) begin
              state_d    = S_RINGING;
              ring_cnt_d = '0;
              blink_d    = 1'b1;
            end else begin
              snooze_cnt_d = snooze_cnt_q + SW'(1);
            end
          end
        end

        default: begin
          state_d = S_IDLE;
          blink_d = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode (registers only)
  // ---------------------------------------------------------------------------
  always_comb begin
    armed       = (state_q != S_IDLE);
    ringing     = (state_q == S_RINGING);
    snoozing    = (state_q == S_SNOOZE);
    buzzer      = (state_q == S_RINGING) & blink_q;
    snooze_left = snooze_left_q;
  end

`ifndef SYNTHESIS
  // Structural invariants of the sequencer.
  a_blink_only_ringing: assert property (@(posedge clk) disable iff (rst)
    (state_q != S_RINGING) |-> !blink_q);
  a_ring_cnt_range: assert property (@(posedge clk) disable iff (rst)
    ring_cnt_q <= RING_LAST);
  a_snooze_cnt_range: assert property (@(posedge clk) disable iff (rst)
    snooze_cnt_q <= SNOOZE_LAST);
  a_snooze_left_range: assert property (@(posedge clk) disable iff (rst)
    snooze_left_q <= SNOOZE_MAX);
`endif

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed vector table, hand-written
// multi-cycle sequences, then random stimulus against a behavioural model.
module tb_alarm_ctrl;

  localparam int RING_T   = 60;
  localparam int SNOOZE_T = 300;
  localparam int MAX_SN   = 3;
  localparam logic [13:0] T_ALARM = 14'h0123;
  localparam logic [13:0] T_OTHER = 14'h0124;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_1hz;
  logic [13:0] cur_time;
  logic [13:0] alarm_time;
  logic        alarm_en;
  logic        btn_stop;
  logic        btn_snooze;
  logic        armed, ringing, snoozing, buzzer;
  logic [1:0]  snooze_left;

  int total = 0;
  int bad   = 0;

  alarm_ctrl #(
    .RING_TIMEOUT_S(RING_T),
    .SNOOZE_S      (SNOOZE_T),
    .MAX_SNOOZE    (MAX_SN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_1hz   (tick_1hz),
    .cur_time   (cur_time),
    .alarm_time (alarm_time),
    .alarm_en   (alarm_en),
    .btn_stop   (btn_stop),
    .btn_snooze (btn_snooze),
    .armed      (armed),
    .ringing    (ringing),
    .snoozing   (snoozing),
    .buzzer     (buzzer),
    .snooze_left(snooze_left)
  );

  always #5 clk = ~clk;

  // Packed view of outputs: {armed, ringing, snoozing, buzzer, snooze_left}
  function automatic logic [5:0] pk(input logic a, input logic r, input logic s,
                                    input logic b, input int sl);
    return {a, r, s, b, 2'(sl)};
  endfunction

  function automatic logic [5:0] outs();
    return {armed, ringing, snoozing, buzzer, snooze_left};
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got a/r/s/b/left=%b_%b_%b_%b_%0d want %b_%b_%b_%b_%0d",
               name, act[5], act[4], act[3], act[2], act[1:0],
               exp[5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  // Advance one clock; outputs are stable 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic tk, input logic stp, input logic snz);
    tick_1hz   = tk;
    btn_stop   = stp;
    btn_snooze = snz;
    step();
    tick_1hz   = 1'b0;
    btn_stop   = 1'b0;
    btn_snooze = 1'b0;
  endtask

  // Leave the matching minute and re-enter it; ringing starts on the next edge.
  task automatic fire(input string name);
    cur_time = T_OTHER;
    cyc(1'b0, 1'b0, 1'b0);
    cur_time = T_ALARM;
    cyc(1'b0, 1'b0, 1'b0);
    check(name, outs(), pk(1, 1, 0, 1, MAX_SN));
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference: mode plus elapsed-tick counts; buzzer follows the
  // parity of ticks rung in the current ringing burst.
  // ---------------------------------------------------------------------------
  typedef enum int {M_OFF, M_WAIT, M_RING, M_SLEEP} mode_e;
  mode_e m_mode;
  int    m_rung, m_slept, m_left;
  bit    m_prev_eq;

  task automatic model_edge();
    bit eq;
    eq = (cur_time == alarm_time);
    if (rst) begin
      m_mode = M_OFF; m_rung = 0; m_slept = 0; m_left = MAX_SN; m_prev_eq = 1'b1;
    end else begin
      bit trig;
      trig = eq && !m_prev_eq;
      m_prev_eq = eq;
      if (!alarm_en) m_mode = M_OFF;
      else begin
        case (m_mode)
          M_OFF:  m_mode = M_WAIT;
          M_WAIT: if (trig) begin m_mode = M_RING; m_rung = 0; m_left = MAX_SN; end
          M_RING: begin
            if (btn_stop) m_mode = M_WAIT;
            else if (btn_snooze && m_left > 0) begin
              m_mode = M_SLEEP; m_slept = 0; m_left--;
            end else if (tick_1hz) begin
              m_rung++;
              if (m_rung == RING_T) m_mode = M_WAIT;
            end
          end
          M_SLEEP: begin
            if (btn_stop) m_mode = M_WAIT;
            else if (tick_1hz) begin
              m_slept++;
              if (m_slept == SNOOZE_T) begin m_mode = M_RING; m_rung = 0; end
            end
          end
          default: m_mode = M_OFF;
        endcase
      end
    end
  endtask

  function automatic logic [5:0] model_out();
    return pk(m_mode != M_OFF, m_mode == M_RING, m_mode == M_SLEEP,
              (m_mode == M_RING) && (m_rung % 2 == 0), m_left);
  endfunction

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        rst;
    logic        en;
    logic        tick;
    logic        stop;
    logic        snz;
    logic [13:0] cur;
    logic [5:0]  exp;
  } vec_t;

  vec_t vecs[16];

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; btn_stop = 1'b0; btn_snooze = 1'b0;
    alarm_en = 1'b1; alarm_time = T_ALARM; cur_time = T_ALARM;

    //          rst   en    tick  stop  snz   cur
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, T_ALARM, pk(0, 0, 0, 0, 3)};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, T_ALARM, pk(1, 0, 0, 0, 3)};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, T_ALARM, pk(1, 0, 0, 0, 3)};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, T_OTHER, pk(1, 0, 0, 0, 3)};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, T_ALARM, pk(1, 1, 0, 1, 3)};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, T_ALARM, pk(1, 1, 0, 0, 3)};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, T_ALARM, pk(1, 1, 0, 1, 3)};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, T_ALARM, pk(1, 0, 1, 0, 2)};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, T_ALARM, pk(1, 0, 1, 0, 2)};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, T_ALARM, pk(1, 0, 0, 0, 2)};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, T_ALARM, pk(1, 0, 0, 0, 2)};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 14'h0000, pk(1, 0, 0, 0, 2)};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, T_ALARM, pk(1, 1, 0, 1, 3)};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, T_ALARM, pk(1, 0, 0, 0, 3)};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, T_ALARM, pk(0, 0, 0, 0, 3)};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, T_ALARM, pk(1, 0, 0, 0, 3)};

    #2;
    for (int i = 0; i < 16; i++) begin
      rst        = vecs[i].rst;
      alarm_en   = vecs[i].en;
      tick_1hz   = vecs[i].tick;
      btn_stop   = vecs[i].stop;
      btn_snooze = vecs[i].snz;
      cur_time   = vecs[i].cur;
      step();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end
    rst = 1'b0; tick_1hz = 1'b0; btn_stop = 1'b0; btn_snooze = 1'b0;
    alarm_en = 1'b1; cur_time = T_ALARM;

    // Unattended ring: buzzer alternates per tick, auto-off after the last tick.
    fire("timeout_fire");
    for (int i = 1; i <= RING_T; i++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (i < RING_T) check($sformatf("timeout_tick%0d", i), outs(), pk(1, 1, 0, i % 2 == 0, 3));
      else            check("timeout_end", outs(), pk(1, 0, 0, 0, 3));
      if (i == 1) begin
        cyc(1'b0, 1'b0, 1'b0);
        check("timeout_hold_between_ticks", outs(), pk(1, 1, 0, 0, 3));
      end
    end
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);
    check("timeout_no_retrigger", outs(), pk(1, 0, 0, 0, 3));

    // Snooze chain; first press coincides with a tick, which is dropped.
    fire("snooze_fire");
    cyc(1'b1, 1'b0, 1'b1);
    check("snooze1_enter", outs(), pk(1, 0, 1, 0, 2));
    for (int i = 0; i < SNOOZE_T - 1; i++) cyc(1'b1, 1'b0, 1'b0);
    check("snooze1_penultimate", outs(), pk(1, 0, 1, 0, 2));
    cyc(1'b1, 1'b0, 1'b0);
    check("snooze1_resume", outs(), pk(1, 1, 0, 1, 2));
    for (int k = 1; k >= 0; k--) begin
      cyc(1'b0, 1'b0, 1'b1);
      check($sformatf("snooze_enter_left%0d", k), outs(), pk(1, 0, 1, 0, k));
      cyc(1'b0, 1'b0, 1'b1);
      check($sformatf("snooze_press_ignored_left%0d", k), outs(), pk(1, 0, 1, 0, k));
      for (int i = 0; i < SNOOZE_T; i++) cyc(1'b1, 1'b0, 1'b0);
      check($sformatf("snooze_resume_left%0d", k), outs(), pk(1, 1, 0, 1, k));
    end
    cyc(1'b0, 1'b0, 1'b1);
    check("snooze4_ignored", outs(), pk(1, 1, 0, 1, 0));
    cyc(1'b0, 1'b1, 1'b0);
    check("snooze_chain_stop", outs(), pk(1, 0, 0, 0, 0));

    // Stop and snooze together: stop wins, snooze_left untouched.
    fire("both_fire");
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < SNOOZE_T; i++) cyc(1'b1, 1'b0, 1'b0);
    check("both_resume", outs(), pk(1, 1, 0, 1, 2));
    cyc(1'b0, 1'b1, 1'b1);
    check("both_stop_wins", outs(), pk(1, 0, 0, 0, 2));

    // Disarm while snoozing, then re-arm and fire again.
    fire("disarm_fire");
    cyc(1'b0, 1'b0, 1'b1);
    alarm_en = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    check("disarm_idle", outs(), pk(0, 0, 0, 0, 2));
    alarm_en = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    check("rearm", outs(), pk(1, 0, 0, 0, 2));
    fire("rearm_fire_reload");

    // Reset mid-ring coinciding with a tick.
    rst = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    check("rst_mid_ring", outs(), pk(0, 0, 0, 0, 3));
    cyc(1'b0, 1'b0, 1'b0);
    check("rst_release_armed", outs(), pk(1, 0, 0, 0, 3));
    cyc(1'b0, 1'b0, 1'b0);
    check("rst_release_no_trigger", outs(), pk(1, 0, 0, 0, 3));

    // Random stimulus against the reference model.
    for (int c = 0; c < 20000; c++) begin
      rst        = (c == 0) || ($urandom_range(0, 2999) == 0);
      alarm_en   = ($urandom_range(0, 1999) != 0);
      tick_1hz   = ($urandom_range(0, 2) == 0);
      btn_stop   = ($urandom_range(0, 399) == 0);
      btn_snooze = ($urandom_range(0, 99) == 0);
      case ($urandom_range(0, 9))
        0:       cur_time = (cur_time == T_ALARM) ? T_OTHER : T_ALARM;
        1:       cur_time = 14'($urandom);
        2:       cur_time = T_ALARM;
        default: ;
      endcase
      model_edge();
      step();
      check($sformatf("rand_cyc%0d", c), outs(), model_out());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Downstream consumer of the minutes/seconds counter's packed 14-bit time word.
- Compares the running time against a stored alarm time and sequences the ring, snooze and stop behaviour from debounced button pulses and a 1 Hz tick.
- Drives the alarm LEDs and buzzer.
- Sits beside the display mux and does not touch the display path.

Parameters:
- RING_TIMEOUT_S, 60: number of 1 Hz ticks an unattended alarm rings before auto-off.
- SNOOZE_S, 300: number of 1 Hz ticks spent in snooze before ringing resumes.
- MAX_SNOOZE, 3: number of snoozes allowed per alarm event.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- tick_1hz  in  1  one-clk-wide pulse once per second.
- cur_time  in  14  packed time: [13:11] tens digit A, [10:7] units digit A, [6:4] tens digit B, [3:0] units digit B.
- alarm_time  in  14  same packing as cur_time; held stable by the setter.
- alarm_en  in  1  level input; 0 disarms the alarm.
- btn_stop  in  1  one-clk pulse from the debounced centre button.
- btn_snooze  in  1  one-clk pulse from the debounced up button.
- armed  out  1  1 when state != IDLE.
- ringing  out  1  1 in RINGING.
- snoozing  out  1  1 in SNOOZE.
- buzzer  out  1  ringing & blink, giving a 1 Hz on/off pattern.
- snooze_left  out  2  remaining snoozes for the current event.

Behaviour:
- All state is in registers updated on posedge clk. All outputs decode from registers; no input reaches an output combinationally.
- Reset values: state=IDLE, ring_cnt=0, snooze_cnt=0, blink=0, snooze_left=MAX_SNOOZE, match_q=1. All outputs are therefore 0, except snooze_left=MAX_SNOOZE.
- Match detection:
  - match = (cur_time == alarm_time); full 14-bit compare.
  - match_q <= match every cycle.
  - trigger = match & ~match_q.
  - match_q resets to 1, so an equal time at reset release does not trigger.
  - The alarm fires once per entry into the matching minute. After a stop it does not re-fire within the same minute.
- FSM states: IDLE, ARMED, RINGING, SNOOZE.
- alarm_en=0 forces IDLE from any state on the next edge. Priority: rst first, then this rule, then the transitions below.
- IDLE -> ARMED when alarm_en=1.
- ARMED -> RINGING on trigger. Same edge: ring_cnt=0, blink=1, snooze_left=MAX_SNOOZE.
- Latency: trigger is seen in cycle n; ringing=1 and buzzer=1 from cycle n+1.
- RINGING, in priority order:
  - btn_stop -> ARMED.
  - btn_snooze with snooze_left != 0 -> SNOOZE; snooze_cnt=0; snooze_left decrements.
  - btn_snooze with snooze_left=0 is ignored.
  - tick_1hz with ring_cnt == RING_TIMEOUT_S-1 -> ARMED (auto-off after exactly RING_TIMEOUT_S ticks).
  - otherwise tick_1hz increments ring_cnt and toggles blink.
- A button pulse coinciding with tick uses the button transition; the tick is dropped.
- SNOOZE:
  - btn_stop -> ARMED.
  - tick_1hz with snooze_cnt == SNOOZE_S-1 -> RINGING; ring_cnt=0, blink=1.
  - otherwise tick_1hz increments snooze_cnt.
  - btn_snooze is ignored.
- blink is 0 in every state except RINGING.
- A trigger arriving in RINGING or SNOOZE is ignored.
- Counter widths:
  - ring_cnt: $clog2(RING_TIMEOUT_S).
  - snooze_cnt: $clog2(SNOOZE_S).
  - Neither counter wraps, because the terminal compare exits the state first.
- snooze_left saturates at 0 and is 2 bits wide, so MAX_SNOOZE <= 3.
- Changing alarm_time or cur_time during RINGING does not affect ringing; only stop, snooze, timeout or alarm_en=0 exit it.
- rst asserted mid-ring: outputs read 0 on the next edge.

Test Plan:
- Reset, alarm_en=1, alarm_time=cur_time=14'h0123 held -> armed=1, no ringing (match_q reset). Then step cur_time to 14'h0124 and back to 14'h0123 -> ringing=1 exactly one clk after the compare edge.
- Ringing, no buttons, 60 ticks -> buzzer toggles each tick (1,0,1,...); after the 60th tick ringing=0, armed=1. Holding cur_time equal produces no re-trigger.
- Ringing, btn_snooze -> snoozing=1, snooze_left=2. After 300 ticks -> ringing=1, buzzer=1. Repeat the snooze twice -> snooze_left=0; the 4th btn_snooze is ignored and ringing stays 1.
- Ringing, btn_stop and btn_snooze in the same cycle -> ARMED (ringing=0, snoozing=0, snooze_left unchanged at 2).
- SNOOZE, drive alarm_en=0 -> all outputs 0 next edge. Re-assert alarm_en -> armed=1, and a new trigger reloads snooze_left=3.
- Ringing, assert rst for 1 cycle coinciding with tick_1hz -> all outputs 0 next edge; the tick has no effect.
